tx_packet_framer: RTL and testbench
===================================

// Module: tx_packet_framer
// PURPOSE
//  Upstream stage of the link-layer transmitter. Accepts 32-bit payload words from the OS/testbench (valid/ready).
//  Builds the 48-bit DATA packet {PID 8'h3c, payload[31:0], CRC8[7:0]} with a bit-serial CRC engine.
//  Offers the packet to the transmitter control FSM and holds it stable through all retries.
//  Reports per-packet success/failure as pulses and saturating counters.
// PARAMETERS
//  N_PKT    48      packet width; fixed at 48; other values unsupported
//  CNT_W    16      width of sent_count / fail_count
// PORTS
//  clk            in   1      clock, all logic on posedge
//  rst_n          in   1      asynchronous, active-low reset
//  in_data        in   32     payload word
//  in_valid       in   1      payload word valid
//  in_ready       out  1      framer can accept a word; transfer when in_valid & in_ready
//  tx_data2send   out  N_PKT  framed packet to transmitter data2send
//  tx_start       out  1      one-cycle start to transmitter
//  tx_avail       in   1      transmitter avail (idle, ready for start)
//  tx_err_code    in   2      transmitter result: 00 ack/success, 10 failure, 11 none, 01 ignored
//  pkt_done       out  1      one-cycle pulse: packet acknowledged
//  pkt_fail       out  1      one-cycle pulse: packet abandoned by transmitter
//  sent_count     out  CNT_W  acknowledged packets, saturating
//  fail_count     out  CNT_W  failed packets, saturating
// BEHAVIOUR
//  Reset values
//   - state IDLE; tx_data2send=0; crc=0; bit_cnt=0
//   - tx_start=0, pkt_done=0, pkt_fail=0, counters=0
//   - in_ready=1 after reset (combinational from IDLE)
//  FSM states IDLE, CALC, OFFER, BUSY
//   - IDLE : in_ready=1; on in_valid: latch word, crc<=0, bit_cnt<=0 -> CALC
//   - CALC : in_ready=0; 32 cycles, one bit per cycle MSB first (word[31-bit_cnt])
//            crc <= {crc[6:0],1'b0} ^ ((crc[7]^bit) ? 8'h07 : 8'h00)
//            CRC: poly x^8+x^2+x+1, init 0, no reflect, no final XOR; over the 32 payload bits only
//            at bit_cnt==31: tx_data2send <= {8'h3c, word, crc_next} -> OFFER
//   - OFFER: tx_start = tx_avail (combinational); if tx_avail -> BUSY; else stay
//   - BUSY : tx_start=0; tx_err_code==00 -> pkt_done pulse, sent_count++, -> IDLE
//            tx_err_code==10 -> pkt_fail pulse, fail_count++, -> IDLE; 11/01 -> stay
//  Latency
//   - accept at cycle t; CALC occupies t+1..t+32; tx_start earliest at t+33
//   - pulse registered one cycle after err_code is sampled; next accept possible that same cycle (IDLE)
//  Rules and boundaries
//   - one packet outstanding; in_ready low in CALC/OFFER/BUSY
//   - tx_data2send changes only at CALC end, so it is stable across all transmitter retries
//   - tx_err_code ignored outside BUSY; tx_avail ignored outside OFFER
//   - tx_start never asserted for more than one cycle per packet
//   - counters saturate at all-ones, no wrap
//   - in_valid dropping while not ready: no effect
//   - async reset mid-packet: packet discarded, all state to reset values immediately
// TESTING
//  - word 32'h0000_0001, tx_avail=1 -> tx_start at accept+33; tx_data2send=48'h3c_0000_0001_07
//  - word 32'h0000_0080 -> tx_data2send=48'h3c_0000_0080_89; word 32'h0 -> 48'h3c_0000_0000_00
//  - tx_avail low 100 cycles in OFFER -> no tx_start, packet held; tx_avail=1 -> single 1-cycle tx_start
//  - BUSY, tx_err_code=11 for 50 cycles then 00 -> one pkt_done, sent_count 0->1, in_ready=1
//  - BUSY, tx_err_code=10 -> one pkt_fail, fail_count+1, sent_count unchanged
//  - BUSY, async rst_n pulse -> state IDLE, outputs 0; counters forced to 0xFFFF -> stay 0xFFFF on next event

Source files
------------

// File: rtl/tx_packet_framer.sv
// Link-layer TX framer: accepts 32-bit payload words and frames them as
// {PID 8'h3c, payload, CRC8} for the transmitter control FSM.
//
// Ports:
//   clk, rst_n     clock (posedge), asynchronous active-low reset
//   in_data        32-bit payload word (valid/ready with in_valid/in_ready)
//   tx_data2send   framed packet, held stable until the next packet is framed
//   tx_start       one-cycle start toward the transmitter (while tx_avail in OFFER)
//   tx_avail       transmitter idle and able to take a start
//   tx_err_code    transmitter result: 00 ack, 10 fail, 11/01 no result yet
//   pkt_done       one-cycle pulse when a packet is acknowledged
//   pkt_fail       one-cycle pulse when a packet is abandoned
//   sent_count     saturating count of acknowledged packets
//   fail_count     saturating count of failed packets

module tx_packet_framer #(
    parameter int N_PKT = 48,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_PKT-1:0] tx_data2send,
    output logic             tx_start,
    input  logic             tx_avail,
    input  logic [1:0]       tx_err_code,
    output logic             pkt_done,
    output logic             pkt_fail,
    output logic [CNT_W-1:0] sent_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam logic [7:0] PID_DATA = 8'h3c;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_OFFER,
        S_BUSY
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [31:0]      word_q;
    logic [7:0]       crc_q;
    logic [7:0]       crc_d;
    logic [4:0]       bit_cnt_q;
    logic [N_PKT-1:0] data_q;
    logic             done_q;
    logic             fail_q;
    logic [CNT_W-1:0] sent_q;
    logic [CNT_W-1:0] failc_q;

    logic accept;
    logic calc_last;
    logic cur_bit;
    logic res_ack;
    logic res_fail;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign calc_last = (state_q == S_CALC) && (bit_cnt_q == 5'd31);
    assign res_ack   = (state_q == S_BUSY) && (tx_err_code == 2'b00);
    assign res_fail  = (state_q == S_BUSY) && (tx_err_code == 2'b10);

    // Payload is fed MSB first, one bit per CALC cycle.
    assign cur_bit = word_q[5'd31 - bit_cnt_q];

    always_comb begin
        crc_d = {crc_q[6:0], 1'b0};
        if (crc_q[7] ^ cur_bit) begin
            crc_d = crc_d ^ CRC_POLY;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (bit_cnt_q == 5'd31) begin
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (tx_avail) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (tx_err_code == 2'b00 || tx_err_code == 2'b10) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // tx_start follows tx_avail in OFFER; leaving OFFER on the same edge
    // guarantees it can never be high for more than one cycle per packet.
    always_comb begin
        in_ready = 1'b0;
        tx_start = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_CALC:  in_ready = 1'b0;
            S_OFFER: tx_start = tx_avail;
            S_BUSY:  tx_start = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            crc_q     <= '0;
            bit_cnt_q <= '0;
        end else if (accept) begin
            word_q    <= in_data;
            crc_q     <= '0;
            bit_cnt_q <= '0;
        end else if (state_q == S_CALC) begin
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_q + 5'd1;
        end
    end

    // The packet register only loads at the end of CALC, so it stays
    // stable across any number of transmitter retries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (calc_last) begin
            data_q <= {PID_DATA, word_q, crc_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            sent_q  <= '0;
            failc_q <= '0;
        end else begin
            done_q <= res_ack;
            fail_q <= res_fail;
            if (res_ack && (sent_q != '1)) begin
                sent_q <= sent_q + 1'b1;
            end
            if (res_fail && (failc_q != '1)) begin
                failc_q <= failc_q + 1'b1;
            end
        end
    end

    assign tx_data2send = data_q;
    assign pkt_done     = done_q;
    assign pkt_fail     = fail_q;
    assign sent_count   = sent_q;
    assign fail_count   = failc_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// Bench for tx_packet_framer: directed and random packets against a
// polynomial-division CRC model and simple packet/counter bookkeeping.

module tb_tx_packet_framer;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] tx_data2send;
    logic        tx_start;
    logic        tx_avail;
    logic [1:0]  tx_err_code;
    logic        pkt_done;
    logic        pkt_fail;
    logic [15:0] sent_count;
    logic [15:0] fail_count;

    // small-counter instance shares all inputs, exercises saturation
    logic        s_in_ready;
    logic [47:0] s_data;
    logic        s_start;
    logic        s_done;
    logic        s_fail;
    logic [1:0]  s_sent;
    logic [1:0]  s_failc;

    int checks;
    int errors;
    int sent_m;
    int fail_m;

    tx_packet_framer #(.N_PKT(48), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tx_data2send (tx_data2send),
        .tx_start     (tx_start),
        .tx_avail     (tx_avail),
        .tx_err_code  (tx_err_code),
        .pkt_done     (pkt_done),
        .pkt_fail     (pkt_fail),
        .sent_count   (sent_count),
        .fail_count   (fail_count)
    );

    tx_packet_framer #(.N_PKT(48), .CNT_W(2)) dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (s_in_ready),
        .tx_data2send (s_data),
        .tx_start     (s_start),
        .tx_avail     (tx_avail),
        .tx_err_code  (tx_err_code),
        .pkt_done     (s_done),
        .pkt_fail     (s_fail),
        .sent_count   (s_sent),
        .fail_count   (s_failc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of (payload * x^8) divided by x^8+x^2+x+1
    function automatic logic [7:0] crc_ref(input logic [31:0] w);
        logic [39:0] r;
        r = {w, 8'h00};
        for (int i = 39; i >= 8; i--) begin
            if (r[i]) r[i-:9] = r[i-:9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [47:0] frame(input logic [31:0] w);
        return {8'h3c, w, crc_ref(w)};
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_sent"}, 64'(sent_count), 64'(sent_m));
        chk({tag, "_fail"}, 64'(fail_count), 64'(fail_m));
        chk({tag, "_sent_s"}, 64'(s_sent), 64'(sat(sent_m, 3)));
        chk({tag, "_fail_s"}, 64'(s_failc), 64'(sat(fail_m, 3)));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        chk({tag, "_data"}, 64'(tx_data2send), 64'd0);
        chk({tag, "_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_done"}, 64'(pkt_done), 64'd0);
        chk({tag, "_pfail"}, 64'(pkt_fail), 64'd0);
        chk({tag, "_s_data"}, 64'(s_data), 64'd0);
        chk_counts(tag);
    endtask

    // One packet: accept, 32 CALC cycles, OFFER for avail_dly cycles with
    // tx_avail low, start, BUSY for busy_dly cycles with no result, then
    // result res (00 ack / 10 fail), or an async reset in BUSY if do_rst.
    task automatic send_pkt(input string tag, input logic [31:0] w,
                            input int avail_dly, input int busy_dly,
                            input logic [1:0] res, input bit do_rst);
        logic [47:0] exp;
        int bad;
        exp = frame(w);
        chk({tag, "_rdy_pre"}, 64'(in_ready), 64'd1);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // CALC: tx_avail, tx_err_code, in_valid all must be ignored
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            in_valid    = 1'($urandom);
            in_data     = $urandom;
            tx_avail    = 1'($urandom);
            tx_err_code = 2'($urandom);
            #1;
            if (tx_start !== 1'b0 || in_ready !== 1'b0 ||
                pkt_done !== 1'b0 || pkt_fail !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk({tag, "_calc_quiet"}, 64'(bad), 64'd0);
        in_valid    = 1'b0;
        tx_err_code = 2'($urandom);
        tx_avail    = 1'b0;
        #1;
        chk({tag, "_data"}, 64'(tx_data2send), 64'(exp));
        chk({tag, "_data_s"}, 64'(s_data), 64'(exp));
        bad = 0;
        for (int i = 0; i < avail_dly; i++) begin
            @(posedge clk); #1;
            tx_err_code = 2'($urandom);
            #1;
            if (tx_start !== 1'b0 || in_ready !== 1'b0 ||
                tx_data2send !== exp) bad++;
        end
        chk({tag, "_offer_hold"}, 64'(bad), 64'd0);
        tx_avail = 1'b1;
        #1;
        chk({tag, "_start"}, 64'(tx_start), 64'd1);
        @(posedge clk); #1;
        tx_avail    = 1'($urandom);
        tx_err_code = 2'b11;
        #1;
        chk({tag, "_start_once"}, 64'(tx_start), 64'd0);
        bad = 0;
        for (int i = 0; i < busy_dly; i++) begin
            @(posedge clk); #1;
            tx_err_code = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
            #1;
            if (pkt_done !== 1'b0 || pkt_fail !== 1'b0 ||
                in_ready !== 1'b0 || tx_start !== 1'b0 ||
                tx_data2send !== exp) bad++;
        end
        chk({tag, "_busy_wait"}, 64'(bad), 64'd0);
        if (do_rst) begin
            #2;
            rst_n = 1'b0;
            #1;
            sent_m = 0;
            fail_m = 0;
            chk_reset_state({tag, "_rst"});
            tx_avail    = 1'b0;
            tx_err_code = 2'b11;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk_reset_state({tag, "_postrst"});
        end else begin
            tx_err_code = res;
            @(posedge clk); #1;
            tx_err_code = 2'b11;
            tx_avail    = 1'b0;
            if (res == 2'b00) sent_m++;
            else fail_m++;
            #1;
            chk({tag, "_done"}, 64'(pkt_done), 64'(res == 2'b00));
            chk({tag, "_pfail"}, 64'(pkt_fail), 64'(res == 2'b10));
            chk({tag, "_rdy_post"}, 64'(in_ready), 64'd1);
            chk_counts(tag);
            @(posedge clk); #1;
            chk({tag, "_pulse_end"}, 64'(pkt_done | pkt_fail), 64'd0);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        sent_m      = 0;
        fail_m      = 0;
        rst_n       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        tx_avail    = 1'b0;
        tx_err_code = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("crc_w1", 64'(frame(32'h1)), 64'h3c_0000_0001_07);
        send_pkt("w1", 32'h0000_0001, 0, 0, 2'b00, 1'b0);
        send_pkt("w80", 32'h0000_0080, 0, 1, 2'b00, 1'b0);
        send_pkt("w0", 32'h0000_0000, 0, 0, 2'b10, 1'b0);
        send_pkt("hold100", 32'hdead_beef, 100, 0, 2'b00, 1'b0);
        send_pkt("busy50", 32'h1234_5678, 0, 50, 2'b00, 1'b0);
        send_pkt("fail", 32'hffff_ffff, 2, 3, 2'b10, 1'b0);

        for (int n = 0; n < 24; n++) begin
            send_pkt("rnd", $urandom, $urandom_range(0, 6),
                     $urandom_range(0, 5),
                     ($urandom_range(0, 2) != 0) ? 2'b00 : 2'b10, 1'b0);
        end

        send_pkt("rstbusy", $urandom, 1, 2, 2'b00, 1'b1);
        send_pkt("after_rst", 32'h0000_0080, 0, 0, 2'b00, 1'b0);
        for (int n = 0; n < 5; n++) begin
            send_pkt("sat", $urandom, 0, 0, 2'b00, 1'b0);
            send_pkt("satf", $urandom, 0, 0, 2'b10, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
